// File: rtl/alu_pkg.sv
// Shared types for the integer issue stage and the ALU behind it.
package alu_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_SLL  = 4'b0010,
    ALU_SLT  = 4'b0100,
    ALU_SLTU = 4'b0110,
    ALU_XOR  = 4'b1000,
    ALU_SRL  = 4'b1010,
    ALU_SRA  = 4'b1011,
    ALU_OR   = 4'b1100,
    ALU_AND  = 4'b1110
  } alu_op_e;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    alu_op_e     op;
    logic [4:0]  rd;
    logic        wb_en;
    logic        illegal;
  } issue_pkt_t;

  // x0 reads as zero; otherwise the bypass beats the register file.
  function automatic logic [31:0] resolve_src(input logic [4:0]  addr,
                                              input logic [31:0] rf_data,
                                              input logic        fwd_valid,
                                              input logic [4:0]  fwd_rd,
                                              input logic [31:0] fwd_data);
    if (addr == 5'd0)                        return 32'd0;
    else if (fwd_valid && (fwd_rd == addr))  return fwd_data;
    else                                     return rf_data;
  endfunction

endpackage

// File: rtl/issue_decode.sv
// Combinational decode: raw instruction fields plus bypass -> issue packet.
module issue_decode
  import alu_pkg::*;
(
  input  logic [6:0]  i_opcode,
  input  logic [2:0]  i_funct3,
  input  logic        i_funct7_5,
  input  logic [4:0]  i_rs1_addr,
  input  logic [4:0]  i_rs2_addr,
  input  logic [4:0]  i_rd,
  input  logic [31:0] i_rs1_data,
  input  logic [31:0] i_rs2_data,
  input  logic [31:0] i_imm,
  input  logic [31:0] i_pc,
  input  logic        i_fwd_valid,
  input  logic [4:0]  i_fwd_rd,
  input  logic [31:0] i_fwd_data,
  output issue_pkt_t  o_pkt
);

  logic [31:0] w_rs1;
  logic [31:0] w_rs2;
  logic        w_is_op;
  logic        w_is_arith;
  alu_op_e     w_alu_op;

  assign w_rs1      = resolve_src(i_rs1_addr, i_rs1_data, i_fwd_valid, i_fwd_rd, i_fwd_data);
  assign w_rs2      = resolve_src(i_rs2_addr, i_rs2_data, i_fwd_valid, i_fwd_rd, i_fwd_data);
  assign w_is_op    = (i_opcode == OPC_OP);
  assign w_is_arith = w_is_op || (i_opcode == OPC_OP_IMM);

  // funct3 -> ALU op; SUB only exists for register-register, SRA for both
  always_comb begin
    w_alu_op = ALU_ADD;
    case (i_funct3)
      3'b000:  w_alu_op = (w_is_op && i_funct7_5) ? ALU_SUB : ALU_ADD;
      3'b001:  w_alu_op = ALU_SLL;
      3'b010:  w_alu_op = ALU_SLT;
      3'b011:  w_alu_op = ALU_SLTU;
      3'b100:  w_alu_op = ALU_XOR;
      3'b101:  w_alu_op = i_funct7_5 ? ALU_SRA : ALU_SRL;
      3'b110:  w_alu_op = ALU_OR;
      default: w_alu_op = ALU_AND;
    endcase
  end

  // operand source selection by opcode; unknown opcodes become a zeroed, illegal ADD
  always_comb begin
    o_pkt    = '0;
    o_pkt.op = ALU_ADD;
    o_pkt.rd = i_rd;
    case (i_opcode)
      OPC_OP:     begin o_pkt.a = w_rs1; o_pkt.b = w_rs2; end
      OPC_OP_IMM: begin o_pkt.a = w_rs1; o_pkt.b = i_imm; end
      OPC_LUI:    begin o_pkt.b = i_imm; end
      OPC_AUIPC:  begin o_pkt.a = i_pc;  o_pkt.b = i_imm; end
      default:    o_pkt.illegal = 1'b1;
    endcase
    if (w_is_arith) o_pkt.op = w_alu_op;
    o_pkt.wb_en = !o_pkt.illegal && (i_rd != 5'd0);
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Registered issue stage in front of the ALU: output register plus one skid
// entry so in_ready comes straight from a flop.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [6:0]      in_opcode,
  input  logic [2:0]      in_funct3,
  input  logic            in_funct7_5,
  input  logic [4:0]      in_rs1_addr,
  input  logic [4:0]      in_rs2_addr,
  input  logic [4:0]      in_rd,
  input  logic [XLEN-1:0] in_rs1_data,
  input  logic [XLEN-1:0] in_rs2_data,
  input  logic [XLEN-1:0] in_imm,
  input  logic [XLEN-1:0] in_pc,
  input  logic            fwd_valid,
  input  logic [4:0]      fwd_rd,
  input  logic [XLEN-1:0] fwd_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] operand_a,
  output logic [XLEN-1:0] operand_b,
  output logic [3:0]      alu_op,
  output logic [4:0]      out_rd,
  output logic            out_wb_en,
  output logic            out_illegal
);

  issue_pkt_t w_pkt;
  issue_pkt_t r_out;
  issue_pkt_t r_skid;
  logic       r_out_valid;
  logic       r_skid_valid;
  logic       w_accept;
  logic       w_out_load;

  issue_decode u_dec (
    .i_opcode    (in_opcode),
    .i_funct3    (in_funct3),
    .i_funct7_5  (in_funct7_5),
    .i_rs1_addr  (in_rs1_addr),
    .i_rs2_addr  (in_rs2_addr),
    .i_rd        (in_rd),
    .i_rs1_data  (in_rs1_data),
    .i_rs2_data  (in_rs2_data),
    .i_imm       (in_imm),
    .i_pc        (in_pc),
    .i_fwd_valid (fwd_valid),
    .i_fwd_rd    (fwd_rd),
    .i_fwd_data  (fwd_data),
    .o_pkt       (w_pkt)
  );

  assign in_ready   = !r_skid_valid && rst_n;
  assign w_accept   = in_valid && in_ready && !flush;
  assign w_out_load = !r_out_valid || out_ready;

  // output/skid pair; the skid always drains first so FIFO order holds
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out        <= '0;
      r_skid       <= '0;
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (flush) begin
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (w_out_load) begin
      if (r_skid_valid) begin
        r_out        <= r_skid;
        r_out_valid  <= 1'b1;
        r_skid_valid <= 1'b0;
      end else if (w_accept) begin
        r_out       <= w_pkt;
        r_out_valid <= 1'b1;
      end else begin
        r_out_valid <= 1'b0;
      end
    end else if (w_accept) begin
      r_skid       <= w_pkt;
      r_skid_valid <= 1'b1;
    end
  end

  assign out_valid   = r_out_valid;
  assign operand_a   = r_out.a;
  assign operand_b   = r_out.b;
  assign alu_op      = r_out.op;
  assign out_rd      = r_out.rd;
  assign out_wb_en   = r_out.wb_en;
  assign out_illegal = r_out.illegal;

endmodule
